// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the streaming matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Accumulator width that holds a sum of n full-width products without wrap.
    function automatic int default_acc_w(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: DW x DW product, extended or truncated to
// ACC_W, summed into an accumulator that restarts on the first term of a row.
module mac_lane
    import matmul_pkg::*;
#(
    parameter int DW     = 16,
    parameter int ACC_W  = default_acc_w(DW, 4),
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             first,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    output logic [ACC_W-1:0] sum
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [2*DW-1:0] prod;
            assign prod     = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
            assign prod_ext = ACC_W'(prod);
        end else begin : g_unsigned
            logic [2*DW-1:0] prod;
            assign prod     = (2*DW)'(a) * (2*DW)'(b);
            assign prod_ext = ACC_W'(prod);
        end
    endgenerate

    // The running sum is visible combinationally so the final term can go
    // straight into the output buffer without an extra cycle.
    assign sum = (first ? '0 : acc) + prod_ext;

    // Accumulator advances only when enabled; a stalled row keeps its partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/matmul_stream_engine.sv
// Streaming N x N matrix multiplier: operands arrive one element per beat,
// N MAC lanes produce one row of C every N cycles into a one-row output buffer.
module matmul_stream_engine
    import matmul_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int ACC_W  = default_acc_w(DW, N),
    parameter int SIGNED = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                keep_b,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*ACC_W-1:0]  out_data,
    output logic [idx_w(N)-1:0] out_row,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam int NN = N * N;
    localparam int IW = idx_w(N);
    localparam int AW = idx_w(NN);
    localparam int CW = idx_w(2 * NN);

    state_t state, state_next;

    logic [CW-1:0]      elem_cnt;
    logic               keep_q;
    logic [DW-1:0]      a_mem [NN];
    logic [DW-1:0]      b_mem [NN];
    logic [IW-1:0]      row_cnt;
    logic [IW-1:0]      k_cnt;
    logic [N*ACC_W-1:0] row_sum;

    logic          accept;
    logic          keep_eff;
    logic          last_beat;
    logic          in_a_phase;
    logic [AW-1:0] wr_a_idx;
    logic [AW-1:0] wr_b_idx;
    logic [AW-1:0] rd_a_idx;
    logic          k_first;
    logic          k_last;
    logic          row_last;
    logic          out_fire;
    logic          buf_load;
    logic          stall;
    logic          lane_en;

    assign accept     = in_valid && in_ready;
    // keep_b is only meaningful on the first beat; afterwards the latched copy rules.
    assign keep_eff   = (state == IDLE) ? keep_b : keep_q;
    assign last_beat  = keep_eff ? (elem_cnt == CW'(NN - 1)) : (elem_cnt == CW'(2 * NN - 1));
    assign in_a_phase = (elem_cnt < CW'(NN));
    assign wr_a_idx   = AW'(elem_cnt);
    assign wr_b_idx   = AW'(elem_cnt - CW'(NN));
    assign rd_a_idx   = AW'(int'(row_cnt) * N + int'(k_cnt));

    assign k_first  = (k_cnt == '0);
    assign k_last   = (k_cnt == IW'(N - 1));
    assign row_last = (row_cnt == IW'(N - 1));
    assign out_fire = out_valid && out_ready;
    // A finished row moves into the buffer if it is empty or draining this cycle.
    assign buf_load = (state == COMPUTE) && k_last && (!out_valid || out_ready);
    assign stall    = (state == COMPUTE) && k_last && !buf_load;
    assign lane_en  = (state == COMPUTE) && !stall;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection plus the handshake and status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = last_beat ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_beat) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (buf_load && row_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && out_last) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter and keep_b latch; the counter returns to zero on the final beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_cnt <= '0;
            keep_q   <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                keep_q <= keep_b;
            end
            elem_cnt <= last_beat ? '0 : elem_cnt + CW'(1);
        end
    end

    // Operand storage: the first N*N beats fill A, the rest fill B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mem <= '{default: '0};
            b_mem <= '{default: '0};
        end else if (accept) begin
            if (in_a_phase) begin
                a_mem[wr_a_idx] <= in_data;
            end else begin
                b_mem[wr_b_idx] <= in_data;
            end
        end
    end

    // Row and term counters; both freeze while a finished row waits for the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            k_cnt   <= '0;
        end else if (lane_en) begin
            if (k_last) begin
                k_cnt   <= '0;
                row_cnt <= row_last ? '0 : row_cnt + IW'(1);
            end else begin
                k_cnt <= k_cnt + IW'(1);
            end
        end
    end

    generate
        for (genvar j = 0; j < N; j++) begin : g_lane
            logic [AW-1:0] rd_b_idx;
            assign rd_b_idx = AW'(int'(k_cnt) * N + j);

            mac_lane #(
                .DW     (DW),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (lane_en),
                .first (k_first),
                .a     (a_mem[rd_a_idx]),
                .b     (b_mem[rd_b_idx]),
                .sum   (row_sum[j*ACC_W +: ACC_W])
            );
        end
    endgenerate

    // One-row output buffer; contents only change when a new row is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else if (buf_load) begin
            out_valid <= 1'b1;
            out_data  <= row_sum;
            out_row   <= row_cnt;
            out_last  <= row_last;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// Directed bench: three engines (unsigned, signed, 8-bit accumulator) share
// the same stimulus so each arithmetic flavour is checked on every run.
module tb_matmul_stream_engine;

    logic        clk;
    logic        rst_n;
    logic        keep_b;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready_u, out_valid_u, out_last_u, busy_u, done_u;
    logic [71:0] out_data_u;
    logic [1:0]  out_row_u;
    logic        in_ready_s, out_valid_s, out_last_s, busy_s, done_s;
    logic [71:0] out_data_s;
    logic [1:0]  out_row_s;
    logic        in_ready_8, out_valid_8, out_last_8, busy_8, done_8;
    logic [31:0] out_data_8;
    logic [1:0]  out_row_8;

    logic [16*8-1:0]  mat_a;
    logic [16*8-1:0]  mat_b;
    logic [16*18-1:0] exp_u;
    logic [16*18-1:0] exp_s;
    logic [16*8-1:0]  exp_8;

    int assert_count = 0;
    int fail_count   = 0;

    matmul_stream_engine #(.N(4), .DW(8), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .keep_b(keep_b), .in_valid(in_valid),
        .in_ready(in_ready_u), .in_data(in_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u), .out_row(out_row_u),
        .out_last(out_last_u), .busy(busy_u), .done(done_u)
    );

    matmul_stream_engine #(.N(4), .DW(8), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .keep_b(keep_b), .in_valid(in_valid),
        .in_ready(in_ready_s), .in_data(in_data), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_row(out_row_s),
        .out_last(out_last_s), .busy(busy_s), .done(done_s)
    );

    matmul_stream_engine #(.N(4), .DW(8), .ACC_W(8), .SIGNED(0)) u_acc8 (
        .clk(clk), .rst_n(rst_n), .keep_b(keep_b), .in_valid(in_valid),
        .in_ready(in_ready_8), .in_data(in_data), .out_valid(out_valid_8),
        .out_ready(out_ready), .out_data(out_data_8), .out_row(out_row_8),
        .out_last(out_last_8), .busy(busy_8), .done(done_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        assert_count++;
        assert (obs === expv) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_in_ready_u"},  128'(in_ready_u),  128'(1));
        check_output({tag, "_out_valid_u"}, 128'(out_valid_u), 128'(0));
        check_output({tag, "_busy_u"},      128'(busy_u),      128'(0));
        check_output({tag, "_done_u"},      128'(done_u),      128'(0));
        check_output({tag, "_out_data_u"},  128'(out_data_u),  128'(0));
        check_output({tag, "_out_row_u"},   128'(out_row_u),   128'(0));
        check_output({tag, "_out_last_u"},  128'(out_last_u),  128'(0));
        check_output({tag, "_in_ready_s"},  128'(in_ready_s),  128'(1));
        check_output({tag, "_out_valid_s"}, 128'(out_valid_s), 128'(0));
        check_output({tag, "_busy_s"},      128'(busy_s),      128'(0));
        check_output({tag, "_done_s"},      128'(done_s),      128'(0));
        check_output({tag, "_out_data_s"},  128'(out_data_s),  128'(0));
        check_output({tag, "_out_row_s"},   128'(out_row_s),   128'(0));
        check_output({tag, "_out_last_s"},  128'(out_last_s),  128'(0));
        check_output({tag, "_in_ready_8"},  128'(in_ready_8),  128'(1));
        check_output({tag, "_out_valid_8"}, 128'(out_valid_8), 128'(0));
        check_output({tag, "_busy_8"},      128'(busy_8),      128'(0));
        check_output({tag, "_done_8"},      128'(done_8),      128'(0));
        check_output({tag, "_out_data_8"},  128'(out_data_8),  128'(0));
        check_output({tag, "_out_row_8"},   128'(out_row_8),   128'(0));
        check_output({tag, "_out_last_8"},  128'(out_last_8),  128'(0));
    endtask

    // Streams A (and B when nbeats is 32); in_ready must hold for every beat
    // and be low on the cycle after the final one.
    task automatic apply_stimulus(input logic kb, input int nbeats);
        for (int e = 0; e < nbeats; e++) begin
            @(negedge clk);
            check_output("in_ready_load", 128'(in_ready_u), 128'(1));
            keep_b   = (e == 0) ? kb : 1'b0;
            in_valid = 1'b1;
            in_data  = (e < 16) ? mat_a[e*8 +: 8] : mat_b[(e-16)*8 +: 8];
        end
        @(negedge clk);
        in_valid = 1'b0;
        keep_b   = 1'b0;
        check_output("in_ready_after_load", 128'(in_ready_u), 128'(0));
    endtask

    // Collects rows starting at first_row with out_ready high; when timed,
    // row r must appear 4*(r+1) negedges after the load ends and done at 16.
    task automatic collect_rows(input int first_row, input logic timed);
        int nrow  = first_row;
        int ndone = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (done_u) begin
                ndone++;
                if (timed) check_output("done_time", 128'(cyc), 128'(16));
            end
            if (out_valid_u) begin
                if (nrow > 3) begin
                    check_output("extra_row", 128'(nrow), 128'(3));
                end else begin
                    check_output("row_idx",  128'(out_row_u),   128'(nrow));
                    check_output("row_last", 128'(out_last_u),  128'(nrow == 3));
                    check_output("data_u",   128'(out_data_u),  128'(exp_u[nrow*72 +: 72]));
                    check_output("data_s",   128'(out_data_s),  128'(exp_s[nrow*72 +: 72]));
                    check_output("data_8",   128'(out_data_8),  128'(exp_8[nrow*32 +: 32]));
                    check_output("valid_s",  128'(out_valid_s), 128'(1));
                    check_output("valid_8",  128'(out_valid_8), 128'(1));
                    check_output("row_s",    128'(out_row_s),   128'(nrow));
                    check_output("last_8",   128'(out_last_8),  128'(nrow == 3));
                    if (timed) check_output("row_time", 128'(cyc), 128'(4 * (nrow + 1)));
                end
                nrow++;
            end
            if (nrow >= 4 && !busy_u) break;
        end
        check_output("row_count",  128'(nrow),       128'(4));
        check_output("done_count", 128'(ndone),      128'(1));
        check_output("idle_after", 128'(busy_u),     128'(0));
        check_output("ready_idle", 128'(in_ready_u), 128'(1));
    endtask

    // A = scale*I, B[r][c] = 4r+c; C = scale*B, or zero when B is known cleared.
    task automatic set_identity_case(input int scale, input logic zero_b);
        int v;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mat_a[(r*4+c)*8 +: 8] = (r == c) ? 8'(scale) : 8'd0;
                mat_b[(r*4+c)*8 +: 8] = 8'(4*r + c);
                v = zero_b ? 0 : scale * (4*r + c);
                exp_u[(r*4+c)*18 +: 18] = 18'(v);
                exp_s[(r*4+c)*18 +: 18] = 18'(v);
                exp_8[(r*4+c)*8 +: 8]   = 8'(v);
            end
        end
    endtask

    task automatic set_uniform_case(input logic [7:0] av, input logic [7:0] bv,
                                    input logic [17:0] eu, input logic [17:0] es,
                                    input logic [7:0] e8);
        for (int x = 0; x < 16; x++) begin
            mat_a[x*8 +: 8]   = av;
            mat_b[x*8 +: 8]   = bv;
            exp_u[x*18 +: 18] = eu;
            exp_s[x*18 +: 18] = es;
            exp_8[x*8 +: 8]   = e8;
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        keep_b    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b1;
        mat_a = '0; mat_b = '0; exp_u = '0; exp_s = '0; exp_8 = '0;

        #2 rst_n = 1'b0;
        @(negedge clk);
        $display("[TB] power-on reset values");
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] identity A times pattern B, full load");
        set_identity_case(1, 1'b0);
        apply_stimulus(1'b0, 32);
        collect_rows(0, 1'b1);

        $display("[TB] keep_b run with A = 2*I");
        set_identity_case(2, 1'b0);
        apply_stimulus(1'b1, 16);
        collect_rows(0, 1'b1);

        $display("[TB] output backpressure for 20 cycles");
        set_identity_case(1, 1'b0);
        out_ready = 1'b0;
        apply_stimulus(1'b1, 16);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(negedge clk);
        for (int h = 0; h < 20; h++) begin
            @(negedge clk);
            check_output("hold_valid", 128'(out_valid_u), 128'(1));
            check_output("hold_row",   128'(out_row_u),   128'(0));
            check_output("hold_data",  128'(out_data_u),  128'(exp_u[0 +: 72]));
            check_output("hold_ready", 128'(in_ready_u),  128'(0));
            check_output("hold_done",  128'(done_u),      128'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_output("release_valid", 128'(out_valid_u), 128'(1));
        check_output("release_row",   128'(out_row_u),   128'(1));
        check_output("release_data",  128'(out_data_u),  128'(exp_u[72 +: 72]));
        collect_rows(2, 1'b0);

        $display("[TB] signed -1 times 2");
        set_uniform_case(8'hFF, 8'h02, 18'h007F8, 18'h3FFF8, 8'hF8);
        apply_stimulus(1'b0, 32);
        collect_rows(0, 1'b1);

        $display("[TB] asynchronous reset during row 2");
        set_identity_case(1, 1'b0);
        apply_stimulus(1'b0, 32);
        repeat (8) @(negedge clk);
        check_output("busy_before_reset", 128'(busy_u), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset("midrun");
        @(negedge clk);
        rst_n = 1'b1;
        for (int q = 0; q < 4; q++) begin
            @(negedge clk);
            check_output("post_reset_done", 128'(done_u),      128'(0));
            check_output("post_reset_idle", 128'(busy_u),      128'(0));
            check_output("post_reset_ov",   128'(out_valid_u), 128'(0));
        end

        $display("[TB] keep_b after reset sees cleared B");
        set_identity_case(1, 1'b1);
        apply_stimulus(1'b1, 16);
        collect_rows(0, 1'b1);

        $display("[TB] all-ones operands, wraps in 8-bit accumulator");
        set_uniform_case(8'hFF, 8'hFF, 18'h3F804, 18'h00004, 8'h04);
        apply_stimulus(1'b0, 32);
        collect_rows(0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
